multi_phase_shift_ctrl: RTL and testbench

MULTI_PHASE_SHIFT_CTRL -- requirements
Module: multi_phase_shift_ctrl

---
 rtl/multi_phase_shift_ctrl.sv | 148 ++++++++++++++
 tb/tb_multi_phase_shift_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_shift_ctrl.sv
// rtl/multi_phase_shift_ctrl.sv - round-robin single-step DCM phase-shift sequencer for NUM_CH channels
// Optional WAIT timeout is built in when macro MPS_TIMEOUT_EN is defined.
module multi_phase_shift_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int PW         = 9,
  parameter int PS_MAX     = 255,
  parameter int PS_TIMEOUT = 1023
) (
  input  logic                 clk_usb,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    load_i,
  input  logic [NUM_CH*PW-1:0] value_i,
  output logic [NUM_CH*PW-1:0] value_o,
  output logic [NUM_CH-1:0]    done_o,
  output logic                 busy_o,
  output logic [NUM_CH-1:0]    dcm_psen_o,
  output logic [NUM_CH-1:0]    dcm_psincdec_o,
  input  logic [NUM_CH-1:0]    dcm_psdone_i,
  input  logic [NUM_CH-1:0]    dcm_ovf_i,
  output logic [NUM_CH-1:0]    err_o,
  input  logic                 err_clr_i
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, STEP, WAIT} state_t;

  state_t               state;
  logic signed [PW-1:0] req [NUM_CH];
  logic signed [PW-1:0] act [NUM_CH];
  logic [CW-1:0]        gnt;
  logic [CW-1:0]        ptr;
  logic [CW-1:0]        sel;
  logic                 sel_found;
  logic                 sel_dir;
  logic                 dir;
  logic [NUM_CH-1:0]    pending;

`ifdef MPS_TIMEOUT_EN
  localparam int TW = $clog2(PS_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`endif

  function automatic logic signed [PW-1:0] clamp(input logic signed [PW-1:0] v);
    int vi;
    vi = int'(v);
    if (vi > PS_MAX) vi = PS_MAX;
    else if (vi < -PS_MAX) vi = -PS_MAX;
    return PW'(vi);
  endfunction

  always_comb begin
    value_o = '0;
    for (int i = 0; i < NUM_CH; i++) value_o[i*PW +: PW] = act[i];
  end

  // Round-robin search starts at ptr, the channel after the last grant.
  always_comb begin
    int idx;
    idx       = 0;
    pending   = '0;
    sel_found = 1'b0;
    sel       = '0;
    for (int i = 0; i < NUM_CH; i++) pending[i] = (req[i] != act[i]) && !err_o[i];
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!sel_found && pending[idx[CW-1:0]]) begin
        sel_found = 1'b1;
        sel       = idx[CW-1:0];
      end
    end
    sel_dir = (req[sel] > act[sel]);
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      gnt            <= '0;
      ptr            <= '0;
      dir            <= 1'b0;
      busy_o         <= 1'b0;
      dcm_psen_o     <= '0;
      dcm_psincdec_o <= '0;
      err_o          <= '0;
      done_o         <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        req[i] <= '0;
        act[i] <= '0;
      end
`ifdef MPS_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_i[i]) req[i] <= clamp(value_i[i*PW +: PW]);
        if (err_clr_i) err_o[i] <= 1'b0;
        done_o[i] <= (act[i] == req[i]) && !(busy_o && (gnt == CW'(i)));
      end

      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt                 <= sel;
            ptr                 <= (int'(sel) == NUM_CH - 1) ? '0 : sel + CW'(1);
            dir                 <= sel_dir;
            busy_o              <= 1'b1;
            dcm_psen_o          <= '0;
            dcm_psen_o[sel]     <= 1'b1;
            dcm_psincdec_o      <= '0;
            dcm_psincdec_o[sel] <= sel_dir;
            state               <= STEP;
          end
        end
        STEP: begin
          dcm_psen_o <= '0;
          state      <= WAIT;
`ifdef MPS_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        WAIT: begin
          // Error set comes after the clear loop above, so it wins.
          if (dcm_psdone_i[gnt]) begin
            if (dcm_ovf_i[gnt]) err_o[gnt] <= 1'b1;
            else if (dir) act[gnt] <= act[gnt] + PW'(1);
            else act[gnt] <= act[gnt] - PW'(1);
            busy_o         <= 1'b0;
            dcm_psincdec_o <= '0;
            state          <= IDLE;
          end
`ifdef MPS_TIMEOUT_EN
          else if (wait_cnt == TW'(PS_TIMEOUT - 1)) begin
            err_o[gnt]     <= 1'b1;
            busy_o         <= 1'b0;
            dcm_psincdec_o <= '0;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_phase_shift_ctrl.sv
// tb/tb_multi_phase_shift_ctrl.sv - randomized scenario bench with DCM model and round-robin reference
// Timeout expectation follows MPS_TIMEOUT_EN when defined.
module tb_multi_phase_shift_ctrl;

  localparam int NUM_CH     = 2;
  localparam int PW         = 9;
  localparam int PS_MAX     = 255;
  localparam int PS_TIMEOUT = 1023;

  logic                 clk_usb;
  logic                 reset_n;
  logic [NUM_CH-1:0]    load_i;
  logic [NUM_CH*PW-1:0] value_i;
  logic [NUM_CH*PW-1:0] value_o;
  logic [NUM_CH-1:0]    done_o;
  logic                 busy_o;
  logic [NUM_CH-1:0]    dcm_psen_o;
  logic [NUM_CH-1:0]    dcm_psincdec_o;
  logic [NUM_CH-1:0]    dcm_psdone_i;
  logic [NUM_CH-1:0]    dcm_ovf_i;
  logic [NUM_CH-1:0]    err_o;
  logic                 err_clr_i;

  multi_phase_shift_ctrl #(
    .NUM_CH(NUM_CH), .PW(PW), .PS_MAX(PS_MAX), .PS_TIMEOUT(PS_TIMEOUT)
  ) dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .load_i(load_i), .value_i(value_i),
    .value_o(value_o), .done_o(done_o), .busy_o(busy_o), .dcm_psen_o(dcm_psen_o),
    .dcm_psincdec_o(dcm_psincdec_o), .dcm_psdone_i(dcm_psdone_i), .dcm_ovf_i(dcm_ovf_i),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  int total = 0;
  int bad   = 0;

  // DCM model state (written only by the model process)
  int   gq[$];
  bit   dq[$];
  int   pend_cnt   = 0;
  int   pend_ch    = 0;
  bit   pend_ovf   = 0;
  int   ch0_pulses = 0;

  // Controls written only by the stimulus process
  int         ovf_on_pulse = -1;
  bit         dcm_hold     = 0;
  bit         spur         = 0;
  logic [1:0] force_done   = 2'b00;

  // Reference model
  int m_act[NUM_CH];
  int m_ptr;
  int exp_g[$];
  bit exp_d[$];

  // PSDONE arrives 4 cycles after each PSEN; spur drives bogus PSDONE+OVF on the idle channel.
  always @(negedge clk_usb) begin
    dcm_psdone_i = '0;
    dcm_ovf_i    = '0;
    if (pend_cnt > 0) begin
      if (spur) begin
        dcm_psdone_i[1-pend_ch] = 1'b1;
        dcm_ovf_i[1-pend_ch]    = 1'b1;
      end
      pend_cnt--;
      if (pend_cnt == 0) begin
        dcm_psdone_i[pend_ch] = 1'b1;
        dcm_ovf_i[pend_ch]    = pend_ovf;
      end
    end
    dcm_psdone_i = dcm_psdone_i | force_done;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dcm_psen_o[i]) begin
        gq.push_back(i);
        dq.push_back(dcm_psincdec_o[i]);
        if (i == 0) ch0_pulses++;
        if (!dcm_hold) begin
          pend_ch  = i;
          pend_cnt = 4;
          pend_ovf = (i == 0) && (ch0_pulses == ovf_on_pulse);
        end
      end
    end
  end

  function automatic int clampv(input int v);
    if (v > PS_MAX) return PS_MAX;
    if (v < -PS_MAX) return -PS_MAX;
    return v;
  endfunction

  function automatic int get_val(input int ch);
    logic signed [PW-1:0] v;
    v = value_o[ch*PW +: PW];
    return int'(v);
  endfunction

  // Expected step list: each grant moves one channel one step toward its target, channels taken in rotation.
  task automatic model_plan(input int t0, input int t1);
    int tgt[NUM_CH];
    int ch;
    bit any;
    exp_g.delete();
    exp_d.delete();
    tgt[0] = clampv(t0);
    tgt[1] = clampv(t1);
    any = 1;
    while (any) begin
      any = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        ch = (m_ptr + k) % NUM_CH;
        if (!any && m_act[ch] != tgt[ch]) begin
          any = 1;
          exp_g.push_back(ch);
          exp_d.push_back(tgt[ch] > m_act[ch]);
          m_act[ch] += (tgt[ch] > m_act[ch]) ? 1 : -1;
          m_ptr = (ch + 1) % NUM_CH;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_usb);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_usb);
    reset_n = 1'b1;
    m_act[0] = 0;
    m_act[1] = 0;
    m_ptr = 0;
  endtask

  task automatic load2(input logic [1:0] mask, input int v0, input int v1);
    logic [PW-1:0] a, b;
    a = PW'(v0);
    b = PW'(v1);
    @(negedge clk_usb);
    load_i  = mask;
    value_i = {b, a};
    @(negedge clk_usb);
    load_i  = '0;
  endtask

  task automatic settle(output bit ok);
    int idle;
    idle = 0;
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_usb);
      if (!busy_o) idle++;
      else idle = 0;
      if (idle >= 10) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_usb);
    total++; if (value_o !== '0) begin bad++; $display("FAIL reset_value got=%h exp=0", value_o); end
    total++; if (done_o !== 2'b11) begin bad++; $display("FAIL reset_done got=%b exp=11", done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (dcm_psen_o !== 2'b00 || dcm_psincdec_o !== 2'b00) begin bad++; $display("FAIL reset_psen got=%b/%b exp=00/00", dcm_psen_o, dcm_psincdec_o); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", err_o); end
    reset_n = 1'b1;
    m_act[0] = 0; m_act[1] = 0; m_ptr = 0;
  endtask

  task automatic test_latency();
    int base;
    bit ok, seq_ok;
    do_reset();
    base = gq.size();
    @(negedge clk_usb);
    load_i  = 2'b01;
    value_i = {9'd0, 9'd3};
    @(posedge clk_usb); #1;
    load_i = '0;
    total++; if (dcm_psen_o !== 2'b00) begin bad++; $display("FAIL latency_edge1 psen got=%b exp=00", dcm_psen_o); end
    @(posedge clk_usb); #1;
    total++; if (dcm_psen_o !== 2'b01 || dcm_psincdec_o !== 2'b01) begin bad++; $display("FAIL latency_edge2 psen/incdec got=%b/%b exp=01/01", dcm_psen_o, dcm_psincdec_o); end
    model_plan(3, 0);
    settle(ok);
    total++; if (!ok) begin bad++; $display("FAIL latency_settle timeout got=busy exp=idle"); end
    seq_ok = (gq.size() - base == exp_g.size());
    for (int k = 0; seq_ok && k < exp_g.size(); k++) if (gq[base+k] != exp_g[k] || dq[base+k] != exp_d[k]) seq_ok = 0;
    total++; if (!seq_ok) begin bad++; $display("FAIL latency_seq got_pulses=%0d exp_pulses=%0d", gq.size() - base, exp_g.size()); end
    total++; if (get_val(0) != 3) begin bad++; $display("FAIL latency_value got=%0d exp=3", get_val(0)); end
    total++; if (done_o !== 2'b11) begin bad++; $display("FAIL latency_done got=%b exp=11", done_o); end
  endtask

  task automatic test_interleave();
    int base;
    bit ok, seq_ok;
    do_reset();
    base = gq.size();
    spur = 1;
    load2(2'b11, 2, -2);
    model_plan(2, -2);
    settle(ok);
    spur = 0;
    total++; if (!ok) begin bad++; $display("FAIL interleave_settle timeout got=busy exp=idle"); end
    seq_ok = (gq.size() - base == exp_g.size());
    for (int k = 0; seq_ok && k < exp_g.size(); k++) if (gq[base+k] != exp_g[k] || dq[base+k] != exp_d[k]) seq_ok = 0;
    total++; if (!seq_ok) begin bad++; $display("FAIL interleave_seq got_pulses=%0d exp_pulses=%0d", gq.size() - base, exp_g.size()); end
    total++; if (get_val(0) != 2 || get_val(1) != -2) begin bad++; $display("FAIL interleave_values got=%0d/%0d exp=2/-2", get_val(0), get_val(1)); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL interleave_spurious_err got=%b exp=00", err_o); end
  endtask

  task automatic test_random();
    int base, v0, v1, t0, t1;
    logic [1:0] mask;
    bit ok, seq_ok;
    for (int r = 0; r < 6; r++) begin
      base = gq.size();
      mask = 2'($urandom_range(1, 3));
      v0 = int'($urandom_range(0, 40)) - 20;
      v1 = int'($urandom_range(0, 40)) - 20;
      t0 = mask[0] ? v0 : m_act[0];
      t1 = mask[1] ? v1 : m_act[1];
      load2(mask, v0, v1);
      model_plan(t0, t1);
      settle(ok);
      seq_ok = ok && (gq.size() - base == exp_g.size());
      for (int k = 0; seq_ok && k < exp_g.size(); k++) if (gq[base+k] != exp_g[k] || dq[base+k] != exp_d[k]) seq_ok = 0;
      total++; if (!seq_ok) begin bad++; $display("FAIL random_seq round=%0d got_pulses=%0d exp_pulses=%0d", r, gq.size() - base, exp_g.size()); end
      total++; if (get_val(0) != m_act[0] || get_val(1) != m_act[1] || done_o !== 2'b11) begin bad++; $display("FAIL random_values round=%0d got=%0d/%0d done=%b exp=%0d/%0d done=11", r, get_val(0), get_val(1), done_o, m_act[0], m_act[1]); end
    end
  endtask

  task automatic test_clamp();
    int base;
    bit ok, seq_ok;
    do_reset();
    base = gq.size();
    load2(2'b01, -256, 0);
    model_plan(-256, 0);
    settle(ok);
    seq_ok = ok && (gq.size() - base == exp_g.size());
    for (int k = 0; seq_ok && k < exp_g.size(); k++) if (gq[base+k] != exp_g[k] || dq[base+k] != exp_d[k]) seq_ok = 0;
    total++; if (!seq_ok) begin bad++; $display("FAIL clamp_seq got_pulses=%0d exp_pulses=%0d", gq.size() - base, exp_g.size()); end
    total++; if (get_val(0) != -PS_MAX) begin bad++; $display("FAIL clamp_value got=%0d exp=%0d", get_val(0), -PS_MAX); end
  endtask

  task automatic test_overflow();
    int c0;
    bit ok;
    do_reset();
    c0 = ch0_pulses;
    ovf_on_pulse = ch0_pulses + 3;
    load2(2'b01, 5, 0);
    settle(ok);
    total++; if (!ok || ch0_pulses - c0 != 3) begin bad++; $display("FAIL ovf_pulses got=%0d exp=3", ch0_pulses - c0); end
    total++; if (get_val(0) != 2) begin bad++; $display("FAIL ovf_act got=%0d exp=2", get_val(0)); end
    total++; if (err_o !== 2'b01 || done_o[0] !== 1'b0) begin bad++; $display("FAIL ovf_err got=%b done0=%b exp=01 done0=0", err_o, done_o[0]); end
    load2(2'b10, 0, 2);
    settle(ok);
    total++; if (!ok || ch0_pulses - c0 != 3 || get_val(1) != 2) begin bad++; $display("FAIL ovf_blocked got_ch0=%0d ch1=%0d exp=3 2", ch0_pulses - c0, get_val(1)); end
    ovf_on_pulse = -1;
    @(negedge clk_usb);
    err_clr_i = 1'b1;
    @(negedge clk_usb);
    err_clr_i = 1'b0;
    settle(ok);
    total++; if (!ok || err_o !== 2'b00 || get_val(0) != 5 || ch0_pulses - c0 != 6) begin bad++; $display("FAIL ovf_clear got err=%b v0=%0d pulses=%0d exp err=00 v0=5 pulses=6", err_o, get_val(0), ch0_pulses - c0); end
  endtask

  task automatic test_hold_and_reset();
    int base;
    bit ok;
    bit exp_busy;
    logic [1:0] exp_err;
`ifdef MPS_TIMEOUT_EN
    exp_busy = 1'b0; exp_err = 2'b10;
`else
    exp_busy = 1'b1; exp_err = 2'b00;
`endif
    do_reset();
    dcm_hold = 1;
    load2(2'b10, 0, 1);
    repeat (PS_TIMEOUT + 80) @(negedge clk_usb);
    total++; if (busy_o !== exp_busy || err_o !== exp_err) begin bad++; $display("FAIL hold got busy=%b err=%b exp busy=%b err=%b", busy_o, err_o, exp_busy, exp_err); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0 || dcm_psen_o !== 2'b00 || dcm_psincdec_o !== 2'b00 || value_o !== '0 || done_o !== 2'b11 || err_o !== 2'b00) begin bad++; $display("FAIL async_reset got busy=%b psen=%b inc=%b val=%h done=%b err=%b exp 0 00 00 0 11 00", busy_o, dcm_psen_o, dcm_psincdec_o, value_o, done_o, err_o); end
    @(negedge clk_usb);
    reset_n = 1'b1;
    dcm_hold = 0;
    base = gq.size();
    @(negedge clk_usb);
    force_done = 2'b11;
    @(negedge clk_usb);
    force_done = 2'b00;
    settle(ok);
    total++; if (!ok || gq.size() != base || value_o !== '0 || err_o !== 2'b00) begin bad++; $display("FAIL late_psdone got pulses=%0d val=%h err=%b exp 0 0 00", gq.size() - base, value_o, err_o); end
  endtask

  initial begin
    reset_n   = 1'b0;
    load_i    = '0;
    value_i   = '0;
    err_clr_i = 1'b0;
    test_reset();
    test_latency();
    test_interleave();
    test_random();
    test_clamp();
    test_overflow();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
